// File: rtl/writeback_regfile_if.sv
// Writeback / register-read bus of the Y86-64 writeback_regfile.
// The master side (execute/memory + decode) drives the retiring instruction
// and read addresses; the slave side (register file) returns read data and status.
interface writeback_regfile_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
);
    logic              wb_valid;
    logic [3:0]        icode;
    logic              cnd;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [WIDTH-1:0]  valE;
    logic [WIDTH-1:0]  valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [WIDTH-1:0]  valA;
    logic [WIDTH-1:0]  valB;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    modport master (
        output wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        input  valA, valB, halted, retired
    );

    modport slave (
        input  wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        output valA, valB, halted, retired
    );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 architectural register file with writeback stage.
// Decodes dstE/dstM from the retiring instruction, commits valE/valM on the
// rising edge (valM wins on a collision), serves two combinational read ports
// with same-cycle bypass, and tracks halt status plus a retired counter.
module writeback_regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 15,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_regfile_if.slave wb
);

    localparam logic [3:0] NO_REG  = 4'hF;
    localparam logic [3:0] RSP     = 4'h4;
    localparam logic [4:0] NREGS_L = 5'(NREGS);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [WIDTH-1:0]  regs_r [NREGS];
    logic [CNT_W-1:0]  retired_r;
    logic [3:0]        dst_e_s;
    logic [3:0]        dst_m_s;
    logic              commit_s;
    logic [WIDTH-1:0]  stored_a_s;
    logic [WIDTH-1:0]  stored_b_s;

    // Read-port value: index F reads zero; otherwise the in-flight M result
    // beats the in-flight E result, which beats the stored register.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [3:0]       src,
        input logic [WIDTH-1:0] stored,
        input logic             en,
        input logic [3:0]       dm,
        input logic [3:0]       de,
        input logic [WIDTH-1:0] vm,
        input logic [WIDTH-1:0] ve
    );
        logic [WIDTH-1:0] res;
        if (src == NO_REG) begin
            res = '0;
        end else if (en && (src == dm)) begin
            res = vm;
        end else if (en && (src == de)) begin
            res = ve;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Only a valid instruction retiring in RUN may write, count or bypass.
    assign commit_s = wb.wb_valid && (state_r == ST_RUN);

    // Destination decode from icode/cnd/rA/rB of the retiring instruction.
    always_comb begin
        dst_e_s = NO_REG;
        dst_m_s = NO_REG;
        if (wb.wb_valid) begin
            case (wb.icode)
                I_CMOV:          dst_e_s = wb.cnd ? wb.rB : NO_REG;
                I_IRMOV, I_OP:   dst_e_s = wb.rB;
                I_CALL, I_RET,
                I_PUSH:          dst_e_s = RSP;
                I_POP: begin
                    dst_e_s = RSP;
                    dst_m_s = wb.rA;
                end
                I_MRMOV:         dst_m_s = wb.rA;
                default: begin
                    dst_e_s = NO_REG;
                    dst_m_s = NO_REG;
                end
            endcase
        end else begin
            dst_e_s = NO_REG;
            dst_m_s = NO_REG;
        end
    end

    // Stored-value lookup for read port A; indices past the file read zero.
    always_comb begin
        stored_a_s = '0;
        if ({1'b0, wb.srcA} < NREGS_L) begin
            stored_a_s = regs_r[wb.srcA];
        end else begin
            stored_a_s = '0;
        end
    end

    // Stored-value lookup for read port B; indices past the file read zero.
    always_comb begin
        stored_b_s = '0;
        if ({1'b0, wb.srcB} < NREGS_L) begin
            stored_b_s = regs_r[wb.srcB];
        end else begin
            stored_b_s = '0;
        end
    end

    assign wb.valA = read_port(wb.srcA, stored_a_s, commit_s, dst_m_s, dst_e_s, wb.valM, wb.valE);
    assign wb.valB = read_port(wb.srcB, stored_b_s, commit_s, dst_m_s, dst_e_s, wb.valM, wb.valE);

    // Register commit: reset loads each register with its own index;
    // a dstE/dstM collision keeps valM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= WIDTH'(i);
            end
        end else if (commit_s) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dst_m_s == 4'(i)) begin
                    regs_r[i] <= wb.valM;
                end else if (dst_e_s == 4'(i)) begin
                    regs_r[i] <= wb.valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // RUN/HALT next-state: a retired halt parks the core until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (commit_s && (wb.icode == I_HALT)) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Retired-instruction counter, free-running wrap, frozen in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= '0;
        end else if (commit_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end
    end

    assign wb.halted  = (state_r == ST_HALT);
    assign wb.retired = retired_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed steps followed by
// randomized retirement traffic against a behavioural register-file model.
module tb_writeback_regfile;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_regfile_if #(.WIDTH(64), .CNT_W(32)) wb ();
    writeback_regfile_if #(.WIDTH(64), .CNT_W(4))  wb2 ();

    writeback_regfile #(.WIDTH(64), .NREGS(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb)
    );
    writeback_regfile #(.WIDTH(64), .NREGS(15), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .wb(wb2)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_reg [15];
    bit          m_halt;
    logic [31:0] m_ret;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_dste(input bit v, input logic [3:0] ic, input bit c, input logic [3:0] rb);
        if (!v) return 4'hF;
        case (ic)
            4'h2:                      return c ? rb : 4'hF;
            4'h3, 4'h6:                return rb;
            4'h8, 4'h9, 4'hA, 4'hB:    return 4'h4;
            default:                   return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] m_dstm(input bit v, input logic [3:0] ic, input logic [3:0] ra);
        if (!v) return 4'hF;
        if (ic == 4'h5 || ic == 4'hB) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src, input bit v, input logic [3:0] ic,
                                           input bit c, input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] de;
        logic [3:0] dm;
        de = m_dste(v, ic, c, rb);
        dm = m_dstm(v, ic, ra);
        if (src == 4'hF) return 64'd0;
        if (!m_halt && src == dm) return vm;
        if (!m_halt && src == de) return ve;
        return m_reg[src];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = 64'(i);
        m_halt = 1'b0;
        m_ret  = 32'd0;
    endtask

    // One retirement cycle: drive at negedge, check reads before the edge,
    // update the model at the edge, then check status after it.
    task automatic step(input string tag, input bit v, input logic [3:0] ic, input bit c,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sb);
        logic [3:0] de;
        logic [3:0] dm;
        @(negedge clk);
        wb.wb_valid = v; wb.icode = ic; wb.cnd = c; wb.rA = ra; wb.rB = rb;
        wb.valE = ve; wb.valM = vm; wb.srcA = sa; wb.srcB = sb;
        #1;
        check({tag, ".valA"}, wb.valA, m_read(sa, v, ic, c, ra, rb, ve, vm));
        check({tag, ".valB"}, wb.valB, m_read(sb, v, ic, c, ra, rb, ve, vm));
        @(posedge clk);
        if (v && !m_halt) begin
            de = m_dste(v, ic, c, rb);
            dm = m_dstm(v, ic, ra);
            if (de != 4'hF) m_reg[de] = ve;
            if (dm != 4'hF) m_reg[dm] = vm;
            m_ret = m_ret + 32'd1;
            if (ic == 4'h0) m_halt = 1'b1;
        end
        #1;
        check({tag, ".halted"}, {63'd0, wb.halted}, {63'd0, m_halt});
        check({tag, ".retired"}, {32'd0, wb.retired}, {32'd0, m_ret});
    endtask

    task automatic read_only(input string tag, input logic [3:0] sa, input logic [3:0] sb);
        step(tag, 1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, sa, sb);
    endtask

    // Async reset pulse that spans a rising edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #6 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] ic;
        wb.wb_valid = 1'b0; wb.icode = 4'h1; wb.cnd = 1'b0; wb.rA = 4'hF; wb.rB = 4'hF;
        wb.valE = 64'd0; wb.valM = 64'd0; wb.srcA = 4'hF; wb.srcB = 4'hF;
        wb2.wb_valid = 1'b0; wb2.icode = 4'h1; wb2.cnd = 1'b0; wb2.rA = 4'hF; wb2.rB = 4'hF;
        wb2.valE = 64'd0; wb2.valM = 64'd0; wb2.srcA = 4'h3; wb2.srcB = 4'hF;
        rst_n = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;

        // Reset state.
        read_only("reset_read", 4'h3, 4'hE);
        check("reset_valA_const", wb.valA, 64'd3);
        check("reset_valB_const", wb.valB, 64'd14);

        // irmovq with same-cycle bypass, then stored value.
        step("irmovq", 1'b1, 4'h3, 1'b0, 4'hF, 4'h2, 64'h55, 64'h0, 4'h2, 4'hF);
        read_only("irmovq_after", 4'h2, 4'hF);
        check("irmovq_reg2", wb.valA, 64'h55);
        check("irmovq_retired", {32'd0, wb.retired}, 64'd1);

        // popq %rsp: M beats E both in bypass and in commit.
        step("popq", 1'b1, 4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hABC, 4'h4, 4'h4);
        read_only("popq_after", 4'h4, 4'hF);
        check("popq_reg4", wb.valA, 64'hABC);

        // cmovXX with cnd=0 then cnd=1.
        step("cmov_nc", 1'b1, 4'h2, 1'b0, 4'hF, 4'h5, 64'h77, 64'h0, 4'h5, 4'hF);
        read_only("cmov_nc_after", 4'h5, 4'hF);
        check("cmov_nc_reg5", wb.valA, 64'd5);
        step("cmov_c", 1'b1, 4'h2, 1'b1, 4'hF, 4'h5, 64'h77, 64'h0, 4'h5, 4'hF);
        read_only("cmov_c_after", 4'h5, 4'hF);
        check("cmov_c_reg5", wb.valA, 64'h77);

        // Unknown icode counts but writes nothing; F reads zero.
        step("unknown", 1'b1, 4'hD, 1'b1, 4'h6, 4'h7, 64'h1234, 64'h5678, 4'h6, 4'h7);
        read_only("unknown_after", 4'h6, 4'hF);

        // halt, then a frozen irmovq.
        step("halt", 1'b1, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 4'hF, 4'hF);
        step("post_halt", 1'b1, 4'h3, 1'b0, 4'hF, 4'h1, 64'd9, 64'd0, 4'h1, 4'hF);
        check("halt_reg1", wb.valA, 64'd1);
        check("halt_retired", {32'd0, wb.retired}, 64'd6);

        // Reset leaves HALT and restores all registers.
        pulse_reset();
        for (int i = 0; i < 15; i += 2) begin
            read_only("restore", 4'(i), 4'(i + 1));
        end

        // Randomized retirement traffic; halt is rare.
        for (int n = 0; n < 300; n++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h0 && $urandom_range(0, 7) != 0) ic = 4'h6;
            step("rand", bit'($urandom_range(0, 3) != 0), ic, bit'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (m_halt && $urandom_range(0, 3) == 0) pulse_reset();
        end

        // Counter wrap on the narrow-counter instance: 15 nops reach all-ones, one more wraps.
        pulse_reset();
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            wb2.wb_valid = 1'b1; wb2.icode = 4'h1;
            @(posedge clk);
            #1;
            if (n == 14) check("wrap_full", {60'd0, wb2.retired}, 64'hF);
        end
        @(negedge clk);
        wb2.wb_valid = 1'b0;
        #1;
        check("wrap_zero", {60'd0, wb2.retired}, 64'd0);
        check("wrap_reg3", wb2.valA, 64'd3);
        check("wrap_halted", {63'd0, wb2.halted}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
